instr_trip_scan_ctrl: RTL and testbench



---
 rtl/instr_trip_scan_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_instr_trip_scan_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_trip_scan_ctrl.sv
// Trip scan sequencer: fetches each sensor value, compares it with its setpoint and publishes all trip bits at end of scan.
// Optional SENSOR_TIMEOUT_EN adds a per-channel ack timeout that forces a fail-safe trip and reports it on sens_fault.
module instr_trip_scan_ctrl #(
   parameter int NChannels = 3,
   parameter int W         = 32,
   parameter int LOW_CH    = 2,
   parameter int TIMEOUT   = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   sens_req,
   output logic [1:0]             sens_ch,
   input  logic                   sens_ack,
   input  logic [W-1:0]           sens_val,
   input  logic [2*NChannels-1:0] mode,
   input  logic                   sp_wr_valid,
   input  logic [1:0]             sp_wr_ch,
   input  logic [W-1:0]           sp_wr_data,
   output logic                   sp_wr_ready,
   output logic [NChannels-1:0]   trip
`ifdef SENSOR_TIMEOUT_EN
   ,
   output logic [NChannels-1:0]   sens_fault
`endif
);

   typedef enum logic [1:0] {IDLE, REQ, CMP, DONE} state_t;

   state_t                 state_reg;
   logic [1:0]             ch_reg;
   logic [W-1:0]           v_reg;
   logic [W-1:0]           sp_cur_reg;
   logic [W-1:0]           sp_reg [NChannels];
   logic [NChannels-1:0]   trip_next_reg;
   logic [NChannels-1:0]   trip_reg;
   logic                   done_reg;
   logic                   busy_reg;
   logic                   sens_req_reg;
   logic                   sp_wr_ready_reg;

   logic [NChannels-1:0]   ch_hit;
   logic [W-1:0]           sp_sel;
   logic [1:0]             mode_sel;
   logic                   sensor_tripped;
   logic                   cmp_bit;
   logic                   last_ch;

   genvar gi;
   generate
      for (gi = 0; gi < NChannels; gi++) begin : g_ch_hit
         assign ch_hit[gi] = (ch_reg == 2'(gi));
      end
      // Only up to four channels fit the 2-bit channel select.
      if (NChannels > 4 || NChannels < 1 || TIMEOUT < 1) begin : g_unsupported_cfg
      end
   endgenerate

   always_comb begin
      sp_sel   = '0;
      mode_sel = 2'd0;
      for (int i = 0; i < NChannels; i++) begin
         if (ch_hit[i]) begin
            sp_sel   = sp_reg[i];
            mode_sel = mode[2*i +: 2];
         end
      end
   end

   assign sensor_tripped = (ch_reg == 2'(LOW_CH)) ? ($signed(v_reg) < $signed(sp_cur_reg))
                                                  : (sp_cur_reg < v_reg);
   assign cmp_bit = (mode_sel == 2'd2) | ((mode_sel == 2'd1) & sensor_tripped);
   assign last_ch = (ch_reg == 2'(NChannels - 1));

   // Setpoints only change while idle, so the scan always sees a stable set.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NChannels; i++) sp_reg[i] <= '0;
      end else if (sp_wr_valid && sp_wr_ready_reg) begin
         for (int i = 0; i < NChannels; i++) begin
            if (sp_wr_ch == 2'(i)) sp_reg[i] <= sp_wr_data;
         end
      end
   end

`ifdef SENSOR_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0]     wait_cnt_reg;
   logic [NChannels-1:0] fault_next_reg;
   logic [NChannels-1:0] fault_reg;
   assign sens_fault = fault_reg;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         ch_reg          <= 2'd0;
         v_reg           <= '0;
         sp_cur_reg      <= '0;
         trip_next_reg   <= '0;
         trip_reg        <= '0;
         done_reg        <= 1'b0;
         busy_reg        <= 1'b0;
         sens_req_reg    <= 1'b0;
         sp_wr_ready_reg <= 1'b1;
`ifdef SENSOR_TIMEOUT_EN
         wait_cnt_reg    <= '0;
         fault_next_reg  <= '0;
         fault_reg       <= '0;
`endif
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  state_reg       <= REQ;
                  ch_reg          <= 2'd0;
                  trip_next_reg   <= '0;
                  busy_reg        <= 1'b1;
                  sens_req_reg    <= 1'b1;
                  sp_wr_ready_reg <= 1'b0;
`ifdef SENSOR_TIMEOUT_EN
                  wait_cnt_reg    <= '0;
                  fault_next_reg  <= '0;
`endif
               end
            end
            REQ: begin
               if (sens_ack) begin
                  v_reg        <= sens_val;
                  sp_cur_reg   <= sp_sel;
                  sens_req_reg <= 1'b0;
                  state_reg    <= CMP;
               end
`ifdef SENSOR_TIMEOUT_EN
               else if (wait_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                  // Silent sensor: trip fail-safe and move on without a compare.
                  trip_next_reg  <= trip_next_reg | ch_hit;
                  fault_next_reg <= fault_next_reg | ch_hit;
                  wait_cnt_reg   <= '0;
                  if (last_ch) begin
                     sens_req_reg <= 1'b0;
                     state_reg    <= DONE;
                  end else begin
                     ch_reg <= ch_reg + 2'd1;
                  end
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + 1'b1;
               end
`endif
            end
            CMP: begin
               trip_next_reg <= (trip_next_reg & ~ch_hit) | (ch_hit & {NChannels{cmp_bit}});
               if (last_ch) begin
                  state_reg <= DONE;
               end else begin
                  ch_reg       <= ch_reg + 2'd1;
                  sens_req_reg <= 1'b1;
                  state_reg    <= REQ;
`ifdef SENSOR_TIMEOUT_EN
                  wait_cnt_reg <= '0;
`endif
               end
            end
            DONE: begin
               trip_reg        <= trip_next_reg;
               done_reg        <= 1'b1;
               busy_reg        <= 1'b0;
               sp_wr_ready_reg <= 1'b1;
               ch_reg          <= 2'd0;
               state_reg       <= IDLE;
`ifdef SENSOR_TIMEOUT_EN
               fault_reg       <= fault_next_reg;
`endif
            end
         endcase
      end
   end

   assign busy        = busy_reg;
   assign done        = done_reg;
   assign sens_req    = sens_req_reg;
   assign sens_ch     = ch_reg;
   assign sp_wr_ready = sp_wr_ready_reg;
   assign trip        = trip_reg;

endmodule

// File: tb/tb_instr_trip_scan_ctrl.sv
// Directed, table-driven bench for instr_trip_scan_ctrl with hand-computed trip vectors.
module tb_instr_trip_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, sens_req;
   logic [1:0]  sens_ch;
   logic        sens_ack = 1'b0;
   logic [31:0] sens_val = '0;
   logic [5:0]  mode = '0;
   logic        sp_wr_valid = 1'b0;
   logic [1:0]  sp_wr_ch = '0;
   logic [31:0] sp_wr_data = '0;
   logic        sp_wr_ready;
   logic [2:0]  trip;
`ifdef SENSOR_TIMEOUT_EN
   logic [2:0]  sens_fault;
`endif

   int pass_cnt = 0;
   int total_cnt = 0;

   instr_trip_scan_ctrl #(.NChannels(3), .W(32), .LOW_CH(2), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .sens_req(sens_req), .sens_ch(sens_ch), .sens_ack(sens_ack), .sens_val(sens_val),
      .mode(mode), .sp_wr_valid(sp_wr_valid), .sp_wr_ch(sp_wr_ch), .sp_wr_data(sp_wr_data),
      .sp_wr_ready(sp_wr_ready), .trip(trip)
`ifdef SENSOR_TIMEOUT_EN
      , .sens_fault(sens_fault)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] sp0, sp1, sp2;
      logic [5:0]  md;
      logic [31:0] v0, v1, v2;
      logic [2:0]  exp_trip;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      else begin
         pass_cnt++;
         $display("ok   %s: %0h", nm, act);
      end
   endtask

   task automatic wr_sp(input logic [1:0] ch, input logic [31:0] data);
      @(negedge clk);
      sp_wr_valid = 1'b1; sp_wr_ch = ch; sp_wr_data = data;
      @(negedge clk);
      sp_wr_valid = 1'b0;
   endtask

   // Start a scan (optionally with a same-cycle setpoint write) and act as the sensor front end.
   // A per-channel delay of -1 means that channel is never acknowledged.
   task automatic run_scan(input logic [31:0] v0, v1, v2, input int d0, d1, d2, input bit noise,
                           input logic [1:0] wch, input logic [31:0] wdata,
                           output int lat, output int first_ch, output int req_err, output int busy_err);
      logic [31:0] vv[3];
      int dd[3];
      int cyc, wcnt, held;
      vv[0] = v0; vv[1] = v1; vv[2] = v2;
      dd[0] = d0; dd[1] = d1; dd[2] = d2;
      lat = -1; first_ch = -1; req_err = 0; busy_err = 0;
      wcnt = 0; held = -1; cyc = 0;
      @(negedge clk);
      start = 1'b1; sp_wr_valid = 1'b1; sp_wr_ch = wch; sp_wr_data = wdata;
      @(negedge clk);
      start = 1'b0; sp_wr_valid = 1'b0;
      while (cyc < 200) begin
         if (done) begin
            lat = cyc;
            break;
         end
         if (busy && sp_wr_ready) busy_err++;
         if (noise && cyc >= 2 && cyc <= 10) begin
            start = 1'b1; sp_wr_valid = 1'b1; sp_wr_ch = 2'd0; sp_wr_data = 32'hFFFF_FFFF;
         end else begin
            start = 1'b0; sp_wr_valid = 1'b0;
         end
         if (sens_req) begin
            if (first_ch < 0) first_ch = int'(sens_ch);
            if (int'(sens_ch) != held) begin
               if (held >= 0 && dd[held] >= 0) req_err++;
               held = int'(sens_ch);
               wcnt = 0;
            end
            if (sens_ch > 2'd2) begin
               req_err++;
               sens_ack = 1'b0;
            end else if (dd[sens_ch] >= 0 && wcnt >= dd[sens_ch]) begin
               sens_ack = 1'b1; sens_val = vv[sens_ch];
            end else begin
               sens_ack = 1'b0; sens_val = 32'hA5A5_A5A5;
            end
            wcnt++;
         end else begin
            sens_ack = 1'b0; held = -1; wcnt = 0;
         end
         @(negedge clk);
         cyc++;
      end
      sens_ack = 1'b0; start = 1'b0; sp_wr_valid = 1'b0;
   endtask

   initial begin
      int lat, fch, rerr, berr, seen;
      vecs[0] = '{32'd100, 32'd100, 32'hFFFF_FFFB, 6'b01_01_01, 32'd150, 32'd50, 32'hFFFF_FFF6, 3'b101};
      vecs[1] = '{32'd100, 32'd100, 32'hFFFF_FFFB, 6'b11_10_00, 32'd150, 32'd50, 32'hFFFF_FFF6, 3'b010};
      vecs[2] = '{32'd100, 32'd100, 32'hFFFF_FFFB, 6'b01_01_01, 32'd100, 32'd100, 32'hFFFF_FFFB, 3'b000};
      vecs[3] = '{32'h7FFF_FFFF, 32'd100, 32'd0, 6'b01_01_01, 32'h8000_0000, 32'd100, 32'hFFFF_FFFF, 3'b101};
      vecs[4] = '{32'd0, 32'd1, 32'h7FFF_FFFF, 6'b01_01_01, 32'd0, 32'h8000_0000, 32'h8000_0000, 3'b110};
      vecs[5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 6'b10_10_10, 32'd0, 32'd0, 32'h8000_0000, 3'b111};
      vecs[6] = '{32'd0, 32'd0, 32'h7FFF_FFFF, 6'b00_11_00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 3'b000};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset_trip", 64'(trip), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_sens_req", 64'(sens_req), 64'd0);
      chk("reset_sens_ch", 64'(sens_ch), 64'd0);
      chk("reset_sp_wr_ready", 64'(sp_wr_ready), 64'd1);

      for (int i = 0; i < 7; i++) begin
         mode = vecs[i].md;
         wr_sp(2'd0, vecs[i].sp0);
         wr_sp(2'd1, vecs[i].sp1);
         wr_sp(2'd3, 32'h0000_DEAD);
         run_scan(vecs[i].v0, vecs[i].v1, vecs[i].v2, 0, 0, 0, 1'b0, 2'd2, vecs[i].sp2,
                  lat, fch, rerr, berr);
         $display("vec %0d: trip=%b exp=%b latency=%0d", i, trip, vecs[i].exp_trip, lat);
         chk($sformatf("vec%0d_trip", i), 64'(trip), 64'(vecs[i].exp_trip));
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd7);
         @(negedge clk);
         chk($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
      end

      // Slow sensor with start pulses and setpoint writes attempted while busy.
      mode = 6'b01_01_01;
      wr_sp(2'd0, 32'd100);
      wr_sp(2'd1, 32'd100);
      run_scan(32'd150, 32'd50, 32'hFFFF_FFF6, 3, 3, 3, 1'b1, 2'd2, 32'hFFFF_FFFB, lat, fch, rerr, berr);
      $display("handshake: trip=%b latency=%0d req_err=%0d busy_err=%0d", trip, lat, rerr, berr);
      chk("hs_trip", 64'(trip), 64'b101);
      chk("hs_latency", 64'(lat), 64'd16);
      chk("hs_req_stable", 64'(rerr), 64'd0);
      chk("hs_ready_low_busy", 64'(berr), 64'd0);
      seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (busy) seen++;
      end
      chk("hs_start_not_queued", 64'(seen), 64'd0);

      // Reset in the first cycle of channel 1's request.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         if (sens_req && sens_ch == 2'd1) begin
            seen = 1;
            break;
         end
         sens_ack = sens_req; sens_val = 32'd150;
         @(negedge clk);
      end
      sens_ack = 1'b0;
      chk("rst_reached_ch1", 64'(seen), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_trip", 64'(trip), 64'd0);
      chk("rst_sens_req", 64'(sens_req), 64'd0);
      rst_n = 1'b1;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (done) seen++;
      end
      chk("rst_no_done", 64'(seen), 64'd0);
      // Setpoints were cleared to zero by the reset; rewrite only ch2 to zero alongside start.
      run_scan(32'd150, 32'd50, 32'hFFFF_FFF6, 0, 0, 0, 1'b0, 2'd2, 32'd0, lat, fch, rerr, berr);
      $display("after reset: trip=%b first_ch=%0d latency=%0d", trip, fch, lat);
      chk("post_rst_first_ch", 64'(fch), 64'd0);
      chk("post_rst_trip", 64'(trip), 64'b111);
      chk("post_rst_latency", 64'(lat), 64'd7);

`ifdef SENSOR_TIMEOUT_EN
      mode = 6'b00_00_00;
      run_scan(32'd150, 32'd50, 32'hFFFF_FFF6, 0, -1, 0, 1'b0, 2'd2, 32'd0, lat, fch, rerr, berr);
      $display("timeout: trip=%b fault=%b latency=%0d", trip, sens_fault, lat);
      chk("to_trip", 64'(trip), 64'b010);
      chk("to_fault", 64'(sens_fault), 64'b010);
      chk("to_latency", 64'(lat), 64'd21);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
